// File: rtl/dft_frame_sched_if.sv
// dft_frame_sched_if: sample-in and result-out streams of the DFT frame scheduler
interface dft_frame_sched_if #(parameter int DATA_W = 16);
  logic              s_valid, s_ready, m_valid, m_last, m_ready;
  logic [DATA_W-1:0] s_data, m_data;
  modport master (output s_valid, s_data, m_ready, input s_ready, m_valid, m_data, m_last);
  modport slave (input s_valid, s_data, m_ready, output s_ready, m_valid, m_data, m_last);
endinterface

// File: rtl/dft_frame_sched.sv
// dft_frame_sched: gathers 4 samples, fires the DFT core, waits with timeout, streams 4 results
module dft_frame_sched #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 1023,
  parameter int LAT_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  dft_frame_sched_if.slave  bus,
  output logic              next,
  output logic [DATA_W-1:0] X0, X1, X2, X3,
  input  logic              next_out,
  input  logic [DATA_W-1:0] Y0, Y1, Y2, Y3,
  output logic              busy,
  output logic [1:0]        err,
  input  logic              err_clr,
  output logic [LAT_W-1:0]  last_lat,
  output logic [15:0]       frames
);
  typedef enum logic [1:0] {COLLECT, FIRE, WAIT, DRAIN} state_t;
  state_t state, state_n;
  logic [1:0] idx, beat;
  logic [3:0][DATA_W-1:0] x, y;
  logic [LAT_W-1:0] cnt;
  logic take, give, expired;
  assign take = bus.s_valid && bus.s_ready;
  assign give = bus.m_valid && bus.m_ready;
  assign expired = cnt == LAT_W'(TIMEOUT);
  assign bus.s_ready = state == COLLECT;
  assign next = state == FIRE;
  assign bus.m_valid = state == DRAIN;
  assign bus.m_data = y[beat];
  assign bus.m_last = bus.m_valid && beat == 2'd3;
  assign busy = state != COLLECT || idx != 2'd0;
  assign {X3, X2, X1, X0} = x;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= COLLECT;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      COLLECT: state_n = take && idx == 2'd3 ? FIRE : COLLECT;
      FIRE:    state_n = WAIT;
      WAIT:    state_n = next_out ? DRAIN : expired ? COLLECT : WAIT;
      DRAIN:   state_n = give && beat == 2'd3 ? COLLECT : DRAIN;
      default: state_n = COLLECT;
    endcase
  end
  // cnt holds the WAIT-cycle number directly, so it is preloaded with 1 on FIRE
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      idx      <= '0;
      beat     <= '0;
      x        <= '0;
      y        <= '0;
      cnt      <= '0;
      err      <= '0;
      last_lat <= '0;
      frames   <= '0;
    end else begin
      if (take) begin
        x[idx] <= bus.s_data;
        idx    <= idx + 2'd1;
      end
      if (state == FIRE) cnt <= LAT_W'(1);
      if (state == WAIT) cnt <= cnt + LAT_W'(1);
      if (state == WAIT && next_out) begin
        y        <= {Y3, Y2, Y1, Y0};
        last_lat <= cnt;
      end
      if (give) begin
        beat <= beat + 2'd1;
        if (beat == 2'd3) frames <= frames + 16'd1;
      end
      err <= (err_clr ? 2'b00 : err) | {next_out && state != WAIT, state == WAIT && !next_out && expired};
    end
endmodule
